// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator command sequencer: opcodes, FSM states,
// default datapath width.
package acc_seq_pkg;

  localparam int unsigned WDefault = 4;

  typedef enum logic [2:0] {
    OpNop = 3'b000,
    OpClr = 3'b001,
    OpLdi = 3'b010,
    OpInc = 3'b011,
    OpDec = 3'b100,
    OpShr = 3'b101,
    OpShl = 3'b110,
    OpAlu = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  // Opcodes whose ISSUE phase repeats cmd_data times.
  function automatic logic is_repeat(op_e op);
    return op inside {OpInc, OpDec, OpShr, OpShl};
  endfunction

endpackage

// File: rtl/rep_counter.sv
// Loadable down-counter that flags the final repeat of a multi-cycle command.
module rep_counter #(
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          last
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign last = (count_q == CW'(1));

endmodule

// File: rtl/acc_sequencer.sv
// Command sequencer: accepts one command at a time, drives register/ALU strobes
// for the required number of cycles, then returns the register value.
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int unsigned W = WDefault
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [2:0]   cmd_oc,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         reg_cl,
  output logic         reg_ld,
  output logic         reg_inc,
  output logic         reg_dec,
  output logic         reg_sr,
  output logic         reg_ir,
  output logic         reg_sl,
  output logic         reg_il,
  output logic [W-1:0] reg_in,
  input  logic [W-1:0] reg_out,
  output logic [2:0]   alu_oc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_f
);

  localparam int unsigned CW = W + 1;

  state_e        state_q;
  op_e           op_q;
  logic [2:0]    oc_q;
  logic [W-1:0]  data_q;
  op_e           cmd_op_e;
  logic          cnt_load;
  logic          cnt_last;
  logic [CW-1:0] cnt_init;
  logic          issue;

  assign cmd_op_e = op_e'(cmd_op);
  assign cnt_load = (state_q == StIdle) && cmd_valid;
  assign issue    = (state_q == StIssue);

  // A zero repeat count stands for 2^W repeats.
  always_comb begin
    cnt_init = CW'(1);
    if (is_repeat(cmd_op_e)) begin
      cnt_init = (cmd_data == '0) ? (CW'(1) << W) : {1'b0, cmd_data};
    end
  end

  rep_counter #(
    .CW (CW)
  ) u_rep_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_init),
    .dec      (issue),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      oc_q    <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q    <= cmd_op_e;
            oc_q    <= cmd_oc;
            data_q  <= cmd_data;
            state_q <= (cmd_op_e == OpNop) ? StResp : StIssue;
          end
        end
        StIssue: begin
          if (cnt_last) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes decode from registered state only, so reset drops them asynchronously.
  always_comb begin
    reg_cl  = issue && (op_q == OpClr);
    reg_ld  = issue && ((op_q == OpLdi) || (op_q == OpAlu));
    reg_inc = issue && (op_q == OpInc);
    reg_dec = issue && (op_q == OpDec);
    reg_sr  = issue && (op_q == OpShr);
    reg_ir  = issue && (op_q == OpShr) && oc_q[0];
    reg_sl  = issue && (op_q == OpShl);
    reg_il  = issue && (op_q == OpShl) && oc_q[0];
    reg_in  = '0;
    if (issue && (op_q == OpLdi)) begin
      reg_in = data_q;
    end else if (issue && (op_q == OpAlu)) begin
      reg_in = alu_f;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_valid ? reg_out : '0;
  assign alu_a     = rst_n ? reg_out : '0;
  assign alu_b     = data_q;
  assign alu_oc    = oc_q;

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter: W, 4, datapath width of the register and ALU the block drives.
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: cmd_valid / cmd_ready  input / output  1 each  command handshake; transfer when both are high at a rising edge.
REQ-005 Port: cmd_op  input  3  command opcode (encodings in REQ-012).
REQ-006 Port: cmd_oc  input  3  ALU opcode for ALU commands; bit 0 is the shift fill bit for SHR/SHL.
REQ-007 Port: cmd_data  input  W  immediate for LDI/ALU; repeat count for INC/DEC/SHR/SHL.
REQ-008 Port: rsp_valid / rsp_ready  output / input  1 each  response handshake; rsp_data  output  W  register value after the command.
REQ-009 Port: reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il  output  1 each  control strobes to the downstream register.
REQ-010 Port: reg_in  output  W  register load data; reg_out  input  W  current register contents.
REQ-011 Port: alu_oc  output  3 and alu_a, alu_b  output  W each  ALU operands; alu_f  input  W  ALU result.

Function
REQ-012 Opcodes SHALL be: 000 NOP, 001 CLR, 010 LDI, 011 INC, 100 DEC, 101 SHR, 110 SHL, 111 ALU.
REQ-013 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-014 In IDLE, cmd_ready SHALL be 1, and cmd_op, cmd_oc and cmd_data SHALL be latched on a command transfer.
REQ-015 A transfer SHALL move the FSM to RESP for NOP and to ISSUE for all other opcodes.
REQ-016 Strobe mapping, asserted only in ISSUE and at most one per cycle:
- CLR: cl
- LDI: ld, with reg_in = latched cmd_data
- INC: inc
- DEC: dec
- SHR: sr, with ir = latched cmd_oc[0]
- SHL: sl, with il = latched cmd_oc[0]
- ALU: ld, with reg_in = alu_f
REQ-017 alu_a SHALL equal reg_out, alu_b SHALL equal the latched cmd_data, and alu_oc SHALL equal the latched cmd_oc in every state.
REQ-018 CLR, LDI and ALU SHALL spend exactly 1 ISSUE cycle.
REQ-019 INC, DEC, SHR and SHL SHALL spend N consecutive ISSUE cycles, where N = cmd_data, and cmd_data = 0 means N = 2^W (16).
REQ-020 The repeat counter SHALL be W+1 bits wide, loaded at acceptance, and decremented once per ISSUE cycle; ISSUE SHALL go to RESP in the cycle the counter reaches 1.
REQ-021 Register arithmetic SHALL wrap modulo 2^W; wrap-around SHALL be the register's own behaviour and SHALL NOT be checked or altered by this block.
REQ-022 In RESP:
- rsp_valid SHALL be 1 and rsp_data SHALL equal reg_out.
- All strobes and cmd_ready SHALL be 0.
- The FSM SHALL hold in RESP until rsp_ready is high at a rising edge, then go to IDLE.
REQ-023 Latency: for a command accepted at edge k, rsp_valid SHALL rise 1 cycle after edge k for NOP and N+1 cycles after edge k otherwise.
REQ-024 Throughput: the block SHALL process one command at a time; a new command SHALL NOT be accepted in the cycle the response completes.
REQ-025 Outside ISSUE, every strobe and reg_in SHALL be 0.

Reset
REQ-026 While rst_n = 0, the block SHALL force state IDLE, the counter and latches to 0, cmd_ready = 1, and rsp_valid, rsp_data, all strobes, reg_in, alu_oc, alu_a and alu_b to 0 (rsp_data and alu_a SHALL be masked to 0 during reset).
REQ-027 Reset asserted mid-ISSUE SHALL abort the command with no response, and strobes SHALL drop asynchronously.

Structure
REQ-028 The opcode encodings, the FSM state type and W's default SHALL live in a shared package, acc_seq_pkg.
REQ-029 The repeat counter SHALL be a sub-module named rep_counter (load, decrement, last flag).
REQ-030 The block SHALL contain no datapath arithmetic beyond the counter.

Verification
REQ-031 The bench SHALL pair the block with the existing alu and register models.
REQ-032 Scenario: reset, then LDI data=1010 -> exactly 1 ld cycle; rsp_valid 2 cycles after acceptance with rsp_data=1010.
REQ-033 Scenario: INC data=0011 from 1110 -> inc high for exactly 3 cycles; rsp_data=0001 (wrap-around).
REQ-034 Scenario: SHL data=0000 oc=001 from 0000 -> 16 sl cycles with il=1; rsp_data=1111; rsp_valid 17 cycles after acceptance.
REQ-035 Scenario: ALU with oc=x, data=0101 -> 1 ld cycle with reg_in equal to alu_f; rsp_data equals the ALU model result.
REQ-036 Scenario: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stay stable, cmd_ready stays 0, no strobes.
REQ-037 Scenario: rst_n pulsed low in the 2nd ISSUE cycle of DEC data=0100 -> strobes drop immediately, no response, cmd_ready=1 after release.
